// File: rtl/flux_tag_arbiter_pkg.sv
// Shared flux definitions: tag width and tag-field position of the tagged word
// written into the shared multi-flow FIFO, plus occupancy counter sizing.
package flux_tag_arbiter_pkg;

    function automatic int flux_tag_w(input int flux);
        return (flux > 1) ? $clog2(flux) : 1;
    endfunction

    // The tag sits directly above the payload: {tag, payload}.
    function automatic int flux_tag_lsb(input int payload_w);
        return payload_w;
    endfunction

    function automatic int flux_cnt_w(input int quota);
        return $clog2(quota + 1);
    endfunction

endpackage

// File: rtl/flux_tag_arbiter_rr_arbiter.sv
// Round-robin grant: searches upward from ptr+1, wrapping at N-1, and grants
// the first requester (one-hot grant plus binary index).
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [PW-1:0] idx_o,
    output logic          any_o
);

    int   k;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        for (int off = 1; off <= N; off++) begin
            k = (int'(ptr_i) + off) % N;
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = PW'(k);
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/flux_tag_arbiter.sv
// Per-flow single-entry holding registers feeding one tagged write stream into
// a shared multi-flow FIFO, with round-robin grant and per-flow occupancy quota.
module flux_tag_arbiter
    import flux_tag_arbiter_pkg::*;
#(
    parameter int FLUX      = 2,
    parameter int PAYLOAD_W = 7,
    parameter int DEPTH     = 8,
    parameter int QUOTA     = 4
) (
    input  logic                                     ck,
    input  logic                                     rst,
    input  logic [FLUX-1:0]                          in_valid,
    input  logic [FLUX*PAYLOAD_W-1:0]                in_data,
    output logic [FLUX-1:0]                          in_ready,
    input  logic                                     full,
    input  logic [FLUX-1:0]                          fifo_rd,
    output logic                                     wr,
    output logic [flux_tag_w(FLUX)+PAYLOAD_W-1:0]    dataout,
    output logic [FLUX-1:0]                          quota_hit
);

    localparam int TAG_W     = flux_tag_w(FLUX);
    localparam int TAG_LSB   = flux_tag_lsb(PAYLOAD_W);
    // A flow can never own more entries than the FIFO has.
    localparam int QUOTA_EFF = (QUOTA < DEPTH) ? QUOTA : DEPTH;
    localparam int CNT_W     = flux_cnt_w(QUOTA_EFF);
    localparam logic [CNT_W-1:0] QUOTA_C = CNT_W'(QUOTA_EFF);

    logic [FLUX-1:0]                hold_valid_q, hold_valid_d;
    logic [FLUX-1:0][PAYLOAD_W-1:0] hold_data_q, hold_data_d;
    logic [FLUX-1:0][CNT_W-1:0]     cnt_q, cnt_d;
    logic [TAG_W-1:0]               rr_ptr_q, rr_ptr_d;

    logic [FLUX-1:0]  eligible;
    logic [FLUX-1:0]  grant;
    logic [TAG_W-1:0] gnt_idx;
    logic [TAG_W-1:0] sel;
    logic             any_elig;
    logic             inc, dec;

    always_comb begin
        eligible  = '0;
        quota_hit = '0;
        for (int i = 0; i < FLUX; i++) begin
            eligible[i]  = hold_valid_q[i] && (cnt_q[i] < QUOTA_C);
            quota_hit[i] = (cnt_q[i] == QUOTA_C);
        end
    end

    rr_arbiter #(
        .N  (FLUX),
        .PW (TAG_W)
    ) u_rr (
        .req_i   (eligible),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant),
        .idx_o   (gnt_idx),
        .any_o   (any_elig)
    );

    // in_ready depends only on registered state, never on full or wr.
    assign in_ready = ~hold_valid_q;
    assign wr       = any_elig & ~full;

    // Idle output points at rr_ptr so it stays defined; forced to 0 in reset.
    always_comb begin
        sel     = wr ? gnt_idx : rr_ptr_q;
        dataout = '0;
        if (!rst) begin
            dataout[TAG_LSB +: TAG_W]  = sel;
            dataout[PAYLOAD_W-1:0]     = hold_data_q[sel];
        end
    end

    always_comb begin
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        cnt_d        = cnt_q;
        rr_ptr_d     = rr_ptr_q;
        inc          = 1'b0;
        dec          = 1'b0;
        if (wr) begin
            hold_valid_d[gnt_idx] = 1'b0;
            rr_ptr_d              = gnt_idx;
        end
        for (int i = 0; i < FLUX; i++) begin
            if (in_valid[i] && !hold_valid_q[i]) begin
                hold_valid_d[i] = 1'b1;
                hold_data_d[i]  = in_data[i*PAYLOAD_W +: PAYLOAD_W];
            end
            // A read of an empty count is ignored; write and read together cancel.
            inc = wr && grant[i];
            dec = fifo_rd[i] && (cnt_q[i] != '0);
            if (inc && !dec) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (dec && !inc) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold_valid_q <= '0;
            hold_data_q  <= '0;
            cnt_q        <= '0;
            rr_ptr_q     <= TAG_W'(FLUX - 1);
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            cnt_q        <= cnt_d;
            rr_ptr_q     <= rr_ptr_d;
        end
    end

endmodule

// File: tb/tb_flux_tag_arbiter.sv
// Directed and randomized checks of flux_tag_arbiter against a behavioural
// model of holding registers, round-robin order and per-flow FIFO occupancy.
module tb_flux_tag_arbiter;

    localparam int FLUX      = 2;
    localparam int PAYLOAD_W = 7;
    localparam int DEPTH     = 8;
    localparam int QUOTA     = 4;

    logic                        ck;
    logic                        rst;
    logic [FLUX-1:0]             in_valid;
    logic [FLUX*PAYLOAD_W-1:0]   in_data;
    logic [FLUX-1:0]             in_ready;
    logic                        full;
    logic [FLUX-1:0]             fifo_rd;
    logic                        wr;
    logic [PAYLOAD_W:0]          dataout;
    logic [FLUX-1:0]             quota_hit;

    flux_tag_arbiter #(
        .FLUX      (FLUX),
        .PAYLOAD_W (PAYLOAD_W),
        .DEPTH     (DEPTH),
        .QUOTA     (QUOTA)
    ) dut (
        .ck        (ck),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .full      (full),
        .fifo_rd   (fifo_rd),
        .wr        (wr),
        .dataout   (dataout),
        .quota_hit (quota_hit)
    );

    initial ck = 1'b0;
    always #5 ck = ~ck;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model: who holds what, how many words each flow owns in the
    // FIFO, and which flow was served last.
    bit m_hv[FLUX];
    int m_hd[FLUX];
    int m_cnt[FLUX];
    int m_rr;
    int m_g;
    bit m_wr;
    int m_dout;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < FLUX; i++) begin
            m_hv[i]  = 1'b0;
            m_hd[i]  = 0;
            m_cnt[i] = 0;
        end
        m_rr = FLUX - 1;
    endtask

    task automatic model_eval();
        m_g = -1;
        for (int off = 1; off <= FLUX; off++) begin
            int f;
            f = (m_rr + off) % FLUX;
            if (m_g < 0 && m_hv[f] && m_cnt[f] < QUOTA) m_g = f;
        end
        m_wr   = (m_g >= 0) && !full;
        m_dout = m_wr ? (m_g * 128 + m_hd[m_g]) : (m_rr * 128 + m_hd[m_rr]);
    endtask

    task automatic model_commit();
        int pre_cnt[FLUX];
        bit pre_hv[FLUX];
        for (int i = 0; i < FLUX; i++) begin
            pre_cnt[i] = m_cnt[i];
            pre_hv[i]  = m_hv[i];
        end
        if (m_wr) begin
            m_hv[m_g]  = 1'b0;
            m_rr       = m_g;
            m_cnt[m_g] = m_cnt[m_g] + 1;
        end
        for (int i = 0; i < FLUX; i++) begin
            if (fifo_rd[i] && pre_cnt[i] > 0) m_cnt[i] = m_cnt[i] - 1;
            if (in_valid[i] && !pre_hv[i]) begin
                m_hv[i] = 1'b1;
                m_hd[i] = int'(in_data[i*PAYLOAD_W +: PAYLOAD_W]);
            end
        end
    endtask

    task automatic at_neg();
        logic [FLUX-1:0] e_rdy;
        logic [FLUX-1:0] e_qh;
        @(negedge ck);
        model_eval();
        for (int i = 0; i < FLUX; i++) begin
            e_rdy[i] = !m_hv[i];
            e_qh[i]  = (m_cnt[i] == QUOTA);
        end
        chk("model_in_ready", 32'(in_ready), 32'(e_rdy));
        chk("model_wr", 32'(wr), 32'(m_wr));
        chk("model_dataout", 32'(dataout), 32'(m_dout));
        chk("model_quota_hit", 32'(quota_hit), 32'(e_qh));
    endtask

    task automatic at_edge();
        model_commit();
        @(posedge ck);
        #1;
    endtask

    task automatic cycle();
        at_neg();
        at_edge();
    endtask

    task automatic set_in(input logic [1:0] v, input logic [6:0] d0, input logic [6:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
    endtask

    // Called at posedge+1: asserts reset between edges and checks outputs at once.
    task automatic reset_mid(input string tag);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk({tag, "_in_ready"}, 32'(in_ready), 32'h3);
        chk({tag, "_wr"}, 32'(wr), 32'h0);
        chk({tag, "_quota_hit"}, 32'(quota_hit), 32'h0);
        chk({tag, "_dataout"}, 32'(dataout), 32'h0);
        @(posedge ck);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = '0;
        in_data  = '0;
        full     = 1'b0;
        fifo_rd  = '0;
        model_reset();
        #3;
        chk("reset_in_ready", 32'(in_ready), 32'h3);
        chk("reset_wr", 32'(wr), 32'h0);
        chk("reset_quota_hit", 32'(quota_hit), 32'h0);
        chk("reset_dataout", 32'(dataout), 32'h0);
        @(posedge ck);
        #1;
        rst = 1'b0;

        // Single flow-0 transfer and write
        set_in(2'b01, 7'h15, 7'h00);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("single_wr", 32'(wr), 32'h1);
        chk("single_dataout", 32'(dataout), 32'h15);
        chk("single_ready0_low", 32'(in_ready[0]), 32'h0);
        at_edge();
        at_neg();
        chk("single_ready0_back", 32'(in_ready[0]), 32'h1);
        at_edge();
        reset_mid("rst_a");

        // Both flows load together
        set_in(2'b11, 7'h15, 7'h2A);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("both_first_wr", 32'(wr), 32'h1);
        chk("both_first_dout", 32'(dataout), 32'h15);
        at_edge();
        at_neg();
        chk("both_second_wr", 32'(wr), 32'h1);
        chk("both_second_dout", 32'(dataout), 32'hAA);
        at_edge();
        set_in(2'b11, 7'h11, 7'h22);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("repeat_first_dout", 32'(dataout), 32'h11);
        at_edge();
        at_neg();
        chk("repeat_second_dout", 32'(dataout), 32'hA2);
        at_edge();

        // Drain flow 0 to zero, then one extra read that must be ignored
        fifo_rd = 2'b01;
        repeat (3) cycle();
        fifo_rd = 2'b00;

        // Flow 1 write with simultaneous read at cnt=2 keeps cnt at 2
        set_in(2'b10, 7'h00, 7'h33);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        fifo_rd = 2'b10;
        at_neg();
        chk("wr_rd_same_wr", 32'(wr), 32'h1);
        chk("wr_rd_same_dout", 32'(dataout), 32'hB3);
        at_edge();
        fifo_rd = 2'b00;
        set_in(2'b10, 7'h00, 7'h34);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        cycle();
        at_neg();
        chk("cnt1_three_no_hit", 32'(quota_hit), 32'h0);
        at_edge();
        set_in(2'b10, 7'h00, 7'h35);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        cycle();
        at_neg();
        chk("cnt1_four_hit", 32'(quota_hit), 32'h2);
        at_edge();
        fifo_rd = 2'b10;
        repeat (2) cycle();
        fifo_rd = 2'b00;

        // Flow 0 reaches its quota from an un-underflowed zero
        for (int k = 0; k < 4; k++) begin
            set_in(2'b01, 7'(8'h40 + k), 7'h00);
            cycle();
            set_in(2'b00, 7'h00, 7'h00);
            cycle();
        end
        at_neg();
        chk("quota0_hit", 32'(quota_hit[0]), 32'h1);
        at_edge();
        set_in(2'b11, 7'h44, 7'h55);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("quota_flow1_passes_wr", 32'(wr), 32'h1);
        chk("quota_flow1_passes_dout", 32'(dataout), 32'hD5);
        at_edge();
        for (int k = 0; k < 2; k++) begin
            at_neg();
            chk("quota_blocked_wr", 32'(wr), 32'h0);
            chk("quota_blocked_ready0", 32'(in_ready[0]), 32'h0);
            at_edge();
        end
        fifo_rd = 2'b01;
        at_neg();
        chk("quota_rd_cycle_wr", 32'(wr), 32'h0);
        at_edge();
        fifo_rd = 2'b00;
        at_neg();
        chk("quota_resume_wr", 32'(wr), 32'h1);
        chk("quota_resume_dout", 32'(dataout), 32'h44);
        at_edge();

        // Backpressure: flow 1 held through three full cycles
        full = 1'b1;
        set_in(2'b10, 7'h00, 7'h2A);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        for (int k = 0; k < 3; k++) begin
            at_neg();
            chk("full_wr", 32'(wr), 32'h0);
            chk("full_dout_stable", 32'(dataout), 32'h44);
            at_edge();
        end
        full = 1'b0;
        at_neg();
        chk("full_release_wr", 32'(wr), 32'h1);
        chk("full_release_dout", 32'(dataout), 32'hAA);
        at_edge();
        at_neg();
        chk("full_single_write", 32'(wr), 32'h0);
        at_edge();

        // Reset in the middle of a burst
        fifo_rd = 2'b11;
        repeat (4) cycle();
        fifo_rd = 2'b00;
        set_in(2'b11, 7'h15, 7'h2A);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("burst_wr", 32'(wr), 32'h1);
        at_edge();
        reset_mid("rst_b");
        cycle();
        set_in(2'b11, 7'h07, 7'h66);
        cycle();
        set_in(2'b00, 7'h00, 7'h00);
        at_neg();
        chk("post_reset_flow0_first", 32'(dataout), 32'h07);
        at_edge();
        at_neg();
        chk("post_reset_flow1_next", 32'(dataout), 32'hE6);
        at_edge();

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            in_valid = 2'($urandom_range(0, 3));
            in_data  = 14'($urandom);
            full     = ($urandom_range(0, 3) == 0);
            fifo_rd  = 2'($urandom_range(0, 3));
            if (n == 200) begin
                reset_mid("rst_rand");
            end else begin
                cycle();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
